// File: rtl/xfcp_frame_fifo.sv
// xfcp_frame_fifo: store-and-forward byte FIFO for one XFCP link direction.
// A frame becomes visible downstream only after its tlast beat is accepted.
// Errored frames (DROP_BAD_FRAME=1) and frames longer than DEPTH are discarded.
// Optional feature macro: XFCP_FRAME_FIFO_STATUS_EN adds the registered
// status_good_frame / status_bad_frame / status_overflow pulse outputs.
module xfcp_frame_fifo #(
  parameter int DEPTH          = 256,
  parameter int DROP_BAD_FRAME = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] xfcp_in_tdata,
  input  logic       xfcp_in_tvalid,
  output logic       xfcp_in_tready,
  input  logic       xfcp_in_tlast,
  input  logic       xfcp_in_tuser,
  output logic [7:0] xfcp_out_tdata,
  output logic       xfcp_out_tvalid,
  input  logic       xfcp_out_tready,
  output logic       xfcp_out_tlast,
  output logic       xfcp_out_tuser
`ifdef XFCP_FRAME_FIFO_STATUS_EN
  ,
  output logic       status_good_frame,
  output logic       status_bad_frame,
  output logic       status_overflow
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] PTR_DEPTH = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_t;

  // Each RAM word is {tuser, tlast, tdata}.
  logic [9:0] mem [DEPTH];

  wr_state_t       state;
  wr_state_t       state_next;
  logic [ADDR_W:0] wr_ptr;      // end of the last committed frame
  logic [ADDR_W:0] wr_ptr_cur;  // write position inside the frame being received
  logic [ADDR_W:0] rd_ptr;

  logic full_cur;
  logic empty;
  logic drop;
  logic in_hs;
  logic fetch;
  logic mem_we;
  logic commit;
  logic rollback;
  logic overflow;

  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;

  assign full_cur = ((wr_ptr_cur - rd_ptr) == PTR_DEPTH);
  assign empty    = (wr_ptr == rd_ptr);
  assign drop     = (state == ST_DROP);
  assign wr_idx   = wr_ptr_cur[ADDR_W-1:0];
  assign rd_idx   = rd_ptr[ADDR_W-1:0];

  // Backpressure only while committed frames exist that will drain; an
  // oversize frame with nothing committed is accepted and then dropped.
  assign xfcp_in_tready = !rst && (!full_cur || drop || empty);
  assign in_hs          = xfcp_in_tvalid && xfcp_in_tready;
  assign fetch          = !empty && (!xfcp_out_tvalid || xfcp_out_tready);

  // Write-side next state and per-beat strobes (store / commit / rollback / overflow).
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    commit     = 1'b0;
    rollback   = 1'b0;
    overflow   = 1'b0;
    if (in_hs) begin
      case (state)
        ST_IDLE, ST_WRITE: begin
          if (full_cur && empty) begin
            // Frame already fills the whole RAM and another beat arrived.
            overflow   = 1'b1;
            state_next = xfcp_in_tlast ? ST_IDLE : ST_DROP;
          end else if (xfcp_in_tlast) begin
            state_next = ST_IDLE;
            if (xfcp_in_tuser && (DROP_BAD_FRAME != 0)) begin
              rollback = 1'b1;
            end else begin
              mem_we = 1'b1;
              commit = 1'b1;
            end
          end else begin
            mem_we     = 1'b1;
            state_next = ST_WRITE;
          end
        end
        ST_DROP: begin
          if (xfcp_in_tlast) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DROP;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

  // Write-side state and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      wr_ptr_cur <= '0;
    end else begin
      state <= state_next;
      if (overflow || rollback) begin
        wr_ptr_cur <= wr_ptr;
      end else if (mem_we) begin
        wr_ptr_cur <= wr_ptr_cur + PTR_ONE;
      end else begin
        wr_ptr_cur <= wr_ptr_cur;
      end
      if (commit) begin
        wr_ptr <= wr_ptr_cur + PTR_ONE;
      end else begin
        wr_ptr <= wr_ptr;
      end
    end
  end

  // Frame RAM write port; tuser is only meaningful on the tlast beat.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= {xfcp_in_tuser & xfcp_in_tlast, xfcp_in_tlast, xfcp_in_tdata};
    end
  end

  // Read side: one-entry output register loaded straight from the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr          <= '0;
      xfcp_out_tvalid <= 1'b0;
      xfcp_out_tdata  <= 8'h00;
      xfcp_out_tlast  <= 1'b0;
      xfcp_out_tuser  <= 1'b0;
    end else if (fetch) begin
      rd_ptr          <= rd_ptr + PTR_ONE;
      xfcp_out_tvalid <= 1'b1;
      xfcp_out_tdata  <= mem[rd_idx][7:0];
      xfcp_out_tlast  <= mem[rd_idx][8];
      xfcp_out_tuser  <= (DROP_BAD_FRAME != 0) ? 1'b0 : mem[rd_idx][9];
    end else if (xfcp_out_tready) begin
      xfcp_out_tvalid <= 1'b0;
    end else begin
      xfcp_out_tvalid <= xfcp_out_tvalid;
    end
  end

`ifdef XFCP_FRAME_FIFO_STATUS_EN
  // Registered one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_good_frame <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_overflow   <= 1'b0;
    end else begin
      status_good_frame <= commit;
      status_bad_frame  <= rollback;
      status_overflow   <= overflow;
    end
  end
`endif

endmodule

// File: tb/tb_xfcp_frame_fifo.sv
// Self-checking bench for xfcp_frame_fifo (DEPTH=16). A queue model of the
// frame rules predicts the output byte stream; directed literal checks pin it.
module tb_xfcp_frame_fifo;

  localparam int DEPTH          = 16;
  localparam int DROP_BAD_FRAME = 1;

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_tdata = 8'h00;
  logic       in_tvalid = 1'b0;
  logic       in_tready;
  logic       in_tlast = 1'b0;
  logic       in_tuser = 1'b0;
  logic [7:0] out_tdata;
  logic       out_tvalid;
  logic       out_tready = 1'b1;
  logic       out_tlast;
  logic       out_tuser;
`ifdef XFCP_FRAME_FIFO_STATUS_EN
  logic       st_good, st_bad, st_ovf;
`endif

  xfcp_frame_fifo #(.DEPTH(DEPTH), .DROP_BAD_FRAME(DROP_BAD_FRAME)) dut (
    .clk(clk), .rst(rst),
    .xfcp_in_tdata(in_tdata), .xfcp_in_tvalid(in_tvalid), .xfcp_in_tready(in_tready),
    .xfcp_in_tlast(in_tlast), .xfcp_in_tuser(in_tuser),
    .xfcp_out_tdata(out_tdata), .xfcp_out_tvalid(out_tvalid), .xfcp_out_tready(out_tready),
    .xfcp_out_tlast(out_tlast), .xfcp_out_tuser(out_tuser)
`ifdef XFCP_FRAME_FIFO_STATUS_EN
    , .status_good_frame(st_good), .status_bad_frame(st_bad), .status_overflow(st_ovf)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  logic [9:0] exp_q [$];   // expected output beats {tuser, tlast, tdata}
  logic [9:0] cur_q [$];   // beats of the frame currently being received
  logic [7:0] out_log [$];
  int   out_frames = 0;
  int   rdy_mode   = 0;    // 0: ready=1, 1: ready=0, 2: random
  logic stalled    = 1'b0;
  int   good_cnt = 0, bad_cnt = 0, ovf_cnt = 0;
  logic [9:0] mw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Output ready generator.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_tready = 1'b1;
      1: out_tready = 1'b0;
      default: out_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Model update and per-cycle output comparison, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cur_q.delete();
    end else begin
      if (out_tvalid) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL out_spurious: got %h/%b with nothing expected", out_tdata, out_tlast);
        end else if ({out_tuser, out_tlast, out_tdata} !== exp_q[0]) begin
          mismatched++;
          $display("FAIL out_beat: got %h, required %h", {out_tuser, out_tlast, out_tdata}, exp_q[0]);
        end
        if (out_tready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          out_log.push_back(out_tdata);
          if (out_tlast) out_frames++;
        end
      end
      if (in_tvalid && in_tready) begin
        cur_q.push_back({1'b0, in_tlast, in_tdata});
        if (in_tlast) begin
          if (!(in_tuser && DROP_BAD_FRAME != 0) && cur_q.size() <= DEPTH) begin
            for (int i = 0; i < cur_q.size(); i++) begin
              mw = cur_q[i];
              if (i == cur_q.size() - 1) mw[9] = (DROP_BAD_FRAME != 0) ? 1'b0 : in_tuser;
              exp_q.push_back(mw);
            end
          end
          cur_q.delete();
        end
      end
`ifdef XFCP_FRAME_FIFO_STATUS_EN
      if (st_good) good_cnt++;
      if (st_bad)  bad_cnt++;
      if (st_ovf)  ovf_cnt++;
`endif
    end
  end

  // Present one beat until accepted; entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] d, input logic l, input logic u, input bit rnd);
    int  waited = 0;
    bit  done = 0;
    while (!done) begin
      in_tdata  = d;
      in_tlast  = l;
      in_tuser  = u;
      in_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (in_tvalid && !in_tready) stalled = 1'b1;
      if (in_tvalid && in_tready) done = 1;
      @(posedge clk);
      #1;
      waited++;
      if (!done && waited > 2000) begin
        compared++;
        mismatched++;
        $display("FAIL send_timeout: byte %h not accepted after %0d cycles", d, waited);
        done = 1;
      end
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    in_tuser  = 1'b0;
  endtask

  task automatic send_frame(input bq_t b, input logic u, input bit rnd);
    for (int i = 0; i < b.size(); i++)
      send_byte(b[i], (i == b.size() - 1), (i == b.size() - 1) ? u : 1'b0, rnd);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_tvalid) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end

  initial begin
    bq_t f;
    int  bf, bb, bg, bd, bo;
    int  exp_frames, exp_bytes, len;
    logic u;

    // Reset values while rst is held.
    #12;
    check("rst_tvalid", 32'(out_tvalid), 32'd0);
    check("rst_tlast",  32'(out_tlast),  32'd0);
    check("rst_tuser",  32'(out_tuser),  32'd0);
    check("rst_tdata",  32'(out_tdata),  32'd0);
    check("rst_tready", 32'(in_tready),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Five-byte good frame and release latency.
    rdy_mode = 0;
    bf = out_frames; bb = out_log.size(); bg = good_cnt;
    f = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(f, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_edge_n", 32'(out_tvalid), 32'd0);
    @(negedge clk);
    check("lat_edge_n1", 32'(out_tvalid), 32'd1);
    check("lat_first",   32'(out_tdata),  32'h01);
    @(posedge clk); #1;
    wait_drain();
    check("f5_frames", 32'(out_frames - bf), 32'd1);
    check("f5_bytes",  32'(out_log.size() - bb), 32'd5);
    check("f5_last",   32'(out_log[bb + 4]), 32'h05);
`ifdef XFCP_FRAME_FIFO_STATUS_EN
    check("f5_good_pulse", 32'(good_cnt - bg), 32'd1);
`endif

    // Errored frame is dropped, following frame passes.
    bf = out_frames; bb = out_log.size(); bd = bad_cnt;
    f = {8'hAA, 8'hBB, 8'hCC};
    send_frame(f, 1'b1, 1'b0);
    f = {8'h11, 8'h22};
    send_frame(f, 1'b0, 1'b0);
    wait_drain();
    check("bad_frames", 32'(out_frames - bf), 32'd1);
    check("bad_bytes",  32'(out_log.size() - bb), 32'd2);
    check("bad_b0",     32'(out_log[bb]), 32'h11);
    check("bad_b1",     32'(out_log[bb + 1]), 32'h22);
`ifdef XFCP_FRAME_FIFO_STATUS_EN
    check("bad_pulse", 32'(bad_cnt - bd), 32'd1);
`endif

    // Oversize 20-byte frame is dropped without backpressure.
    bf = out_frames; bb = out_log.size(); bo = ovf_cnt;
    stalled = 1'b0;
    f = {};
    for (int i = 0; i < 20; i++) f.push_back(8'(8'h30 + i));
    send_frame(f, 1'b0, 1'b0);
    check("ovf_no_stall", 32'(stalled), 32'd0);
    f = {8'h61, 8'h62, 8'h63};
    send_frame(f, 1'b0, 1'b0);
    wait_drain();
    check("ovf_frames", 32'(out_frames - bf), 32'd1);
    check("ovf_bytes",  32'(out_log.size() - bb), 32'd3);
    check("ovf_b0",     32'(out_log[bb]), 32'h61);
    check("ovf_b2",     32'(out_log[bb + 2]), 32'h63);
`ifdef XFCP_FRAME_FIFO_STATUS_EN
    check("ovf_pulse", 32'(ovf_cnt - bo), 32'd1);
`endif

    // Exactly DEPTH bytes with the output blocked: commits, next frame stalls.
    bf = out_frames; bb = out_log.size();
    rdy_mode = 1;
    out_tready = 1'b0;
    stalled = 1'b0;
    f = {};
    for (int i = 0; i < 16; i++) f.push_back(8'(8'h80 + i));
    send_frame(f, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("full_valid", 32'(out_tvalid), 32'd1);
    check("full_head",  32'(out_tdata),  32'h80);
    f = {8'h90, 8'h91};
    fork
      send_frame(f, 1'b0, 1'b0);
      begin
        repeat (6) @(negedge clk);
        check("full_stall_tready", 32'(in_tready), 32'd0);
        rdy_mode = 0;
      end
    join
    check("full_stalled", 32'(stalled), 32'd1);
    wait_drain();
    check("full_frames", 32'(out_frames - bf), 32'd2);
    check("full_bytes",  32'(out_log.size() - bb), 32'd18);
    check("full_b15",    32'(out_log[bb + 15]), 32'h8F);
    check("full_b16",    32'(out_log[bb + 16]), 32'h90);

    // Random valid/ready over 200 frames of 1..16 bytes.
    bf = out_frames; bb = out_log.size();
    exp_frames = 0; exp_bytes = 0;
    rdy_mode = 2;
    for (int fr = 0; fr < 200; fr++) begin
      len = $urandom_range(1, 16);
      u = ($urandom_range(0, 7) == 0);
      f = {};
      for (int i = 0; i < len; i++) f.push_back(8'($urandom));
      if (!u) begin
        exp_frames++;
        exp_bytes += len;
      end
      send_frame(f, u, 1'b1);
    end
    wait_drain();
    rdy_mode = 0;
    check("rnd_frames", 32'(out_frames - bf), 32'(exp_frames));
    check("rnd_bytes",  32'(out_log.size() - bb), 32'(exp_bytes));

    // Reset in the middle of a frame, with a committed frame held at the output.
    rdy_mode = 1;
    out_tready = 1'b0;
    f = {8'h50, 8'h51, 8'h52, 8'h53};
    send_frame(f, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(out_tvalid), 32'd1);
    send_byte(8'hC0, 1'b0, 1'b0, 1'b0);
    send_byte(8'hC1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hC2, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 32'(out_tvalid), 32'd0);
    check("mid_rst_tdata",  32'(out_tdata),  32'd0);
    check("mid_rst_tlast",  32'(out_tlast),  32'd0);
    check("mid_rst_tready", 32'(in_tready),  32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 0;
    bf = out_frames; bb = out_log.size();
    f = {};
    for (int i = 0; i < 8; i++) f.push_back(8'(8'hD0 + i));
    send_frame(f, 1'b0, 1'b0);
    wait_drain();
    check("post_rst_frames", 32'(out_frames - bf), 32'd1);
    check("post_rst_bytes",  32'(out_log.size() - bb), 32'd8);
    check("post_rst_b0",     32'(out_log[bb]), 32'hD0);
    check("post_rst_b7",     32'(out_log[bb + 7]), 32'hD7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
